// File: rtl/demux_pkg.sv
// Shared definitions for the time-division demultiplexer: state encoding
// and the slot counter width helper.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slot counter width: clog2 of the channel count, never narrower than one bit.
  function automatic int slot_cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tdm_demux.sv
// Time-division demultiplexer. Collects N_CH consecutive accepted samples,
// starting at a frame marker, into a staging register and presents the
// completed frame in parallel on dout with a one-cycle dout_valid pulse.
// A frame marker arriving mid-frame restarts collection and flags sync_err.
module tdm_demux #(
  parameter int DATA_W = 2,
  parameter int N_CH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_start,
  output logic [N_CH*DATA_W-1:0]   dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     sync_err
);

  import demux_pkg::*;

  localparam int                 CNT_W     = slot_cnt_width(N_CH);
  localparam int                 FRAME_W   = N_CH * DATA_W;
  localparam logic [CNT_W-1:0]   LAST_SLOT = CNT_W'(N_CH - 1);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    slot_cnt_r, slot_cnt_s;
  logic [FRAME_W-1:0]  staging_r, staging_s;
  logic [FRAME_W-1:0]  dout_r, dout_s;
  logic [FRAME_W-1:0]  frame_s;
  logic                dout_valid_r, dout_valid_s;
  logic                busy_r;
  logic                sync_err_r, sync_err_s;

  // Next-state logic: slot collection, resync handling and frame completion.
  always_comb begin
    state_s      = state_r;
    slot_cnt_s   = slot_cnt_r;
    staging_s    = staging_r;
    dout_s       = dout_r;
    dout_valid_s = 1'b0;
    sync_err_s   = 1'b0;
    // Completed frame: staged slots with the final slot taken straight from din.
    frame_s      = staging_r;
    frame_s[(N_CH-1)*DATA_W +: DATA_W] = din;

    if (din_valid) begin
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            if (N_CH == 1) begin
              dout_s       = frame_s;
              dout_valid_s = 1'b1;
            end else begin
              staging_s[DATA_W-1:0] = din;
              slot_cnt_s            = CNT_W'(1);
              state_s               = RUN;
            end
          end else begin
            // Samples outside a frame are dropped silently.
            state_s = IDLE;
          end
        end
        RUN: begin
          if (frame_start) begin
            // Resync: abandon the partial frame and restart at slot 0.
            staging_s[DATA_W-1:0] = din;
            slot_cnt_s            = CNT_W'(1);
            sync_err_s            = 1'b1;
          end else if (slot_cnt_r == LAST_SLOT) begin
            dout_s       = frame_s;
            dout_valid_s = 1'b1;
            slot_cnt_s   = {CNT_W{1'b0}};
            state_s      = IDLE;
          end else begin
            for (int k = 0; k < N_CH; k++) begin
              if (slot_cnt_r == CNT_W'(k)) begin
                staging_s[k*DATA_W +: DATA_W] = din;
              end else begin
                staging_s[k*DATA_W +: DATA_W] = staging_r[k*DATA_W +: DATA_W];
              end
            end
            slot_cnt_s = slot_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s    = IDLE;
          slot_cnt_s = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      // No accepted sample: all state holds, strobes stay low.
      dout_valid_s = 1'b0;
    end
  end

  // State, staging and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      slot_cnt_r   <= {CNT_W{1'b0}};
      staging_r    <= {FRAME_W{1'b0}};
      dout_r       <= {FRAME_W{1'b0}};
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      slot_cnt_r   <= slot_cnt_s;
      staging_r    <= staging_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      busy_r       <= (state_s == RUN);
      sync_err_r   <= sync_err_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: hand-computed vector table for the directed
// scenarios, then a randomized stream checked against a queue-based model.
module tb_tdm_demux;

  localparam int DATA_W = 2;
  localparam int N_CH   = 4;
  localparam int FW     = DATA_W * N_CH;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              frame_start;
  logic [FW-1:0]     dout;
  logic              dout_valid;
  logic              busy;
  logic              sync_err;

  int checks;
  int failures;

  typedef struct {
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              v;
    logic              fs;
    logic [FW-1:0]     dout;
    logic              dv;
    logic              busy;
    logic              se;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: samples of the frame being collected.
  logic [DATA_W-1:0] mq[$];
  logic [FW-1:0]     m_dout;
  logic              m_dv;
  logic              m_se;

  tdm_demux #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [DATA_W-1:0] d, input logic v,
                     input logic fs, input logic [FW-1:0] edout, input logic edv,
                     input logic ebusy, input logic ese);
    vec_t t;
    t.rst = r; t.din = d; t.v = v; t.fs = fs;
    t.dout = edout; t.dv = edv; t.busy = ebusy; t.se = ese;
    tbl.push_back(t);
  endtask

  // Apply one cycle of inputs and return after the edge has settled.
  task automatic drive(input logic r, input logic [DATA_W-1:0] d, input logic v,
                       input logic fs);
    rst = r; din = d; din_valid = v; frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  // Model update for one clock edge, derived from the frame rules.
  task automatic model_step(input logic r, input logic [DATA_W-1:0] d, input logic v,
                            input logic fs);
    m_dv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else if (v) begin
      if (fs) begin
        m_se = (mq.size() != 0);
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() != 0) begin
        mq.push_back(d);
      end
      if (mq.size() == N_CH) begin
        for (int k = 0; k < N_CH; k++) m_dout[k*DATA_W +: DATA_W] = mq[k];
        m_dv = 1'b1;
        mq.delete();
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;

    // 1: reset with active inputs
    add(1, 2'd3, 1, 1, 8'h00, 0, 0, 0);
    add(1, 2'd1, 1, 0, 8'h00, 0, 0, 0);
    // 2: frame 10,01,11,00
    add(0, 2'd2, 1, 1, 8'h00, 0, 1, 0);
    add(0, 2'd1, 1, 0, 8'h00, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'h00, 0, 1, 0);
    add(0, 2'd0, 1, 0, 8'h36, 1, 0, 0);
    add(0, 2'd0, 0, 0, 8'h36, 0, 0, 0);
    // 3: same frame with bubbles (bubble inputs carry junk)
    add(0, 2'd2, 1, 1, 8'h36, 0, 1, 0);
    add(0, 2'd3, 0, 1, 8'h36, 0, 1, 0);
    add(0, 2'd1, 1, 0, 8'h36, 0, 1, 0);
    add(0, 2'd0, 0, 1, 8'h36, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'h36, 0, 1, 0);
    add(0, 2'd2, 0, 0, 8'h36, 0, 1, 0);
    add(0, 2'd0, 1, 0, 8'h36, 1, 0, 0);
    add(0, 2'd1, 0, 1, 8'h36, 0, 0, 0);
    // 4: resync mid-frame
    add(0, 2'd3, 1, 1, 8'h36, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'h36, 0, 1, 0);
    add(0, 2'd1, 1, 1, 8'h36, 0, 1, 1);
    add(0, 2'd2, 1, 0, 8'h36, 0, 1, 0);
    add(0, 2'd0, 1, 0, 8'h36, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'hC9, 1, 0, 0);
    // 5: leading samples without a frame marker are ignored
    add(0, 2'd1, 1, 0, 8'hC9, 0, 0, 0);
    add(0, 2'd2, 1, 0, 8'hC9, 0, 0, 0);
    add(0, 2'd0, 1, 1, 8'hC9, 0, 1, 0);
    add(0, 2'd0, 1, 0, 8'hC9, 0, 1, 0);
    add(0, 2'd0, 1, 0, 8'hC9, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'hC0, 1, 0, 0);
    // 6: back-to-back frames, then reset inside a third frame
    add(0, 2'd1, 1, 1, 8'hC0, 0, 1, 0);
    add(0, 2'd2, 1, 0, 8'hC0, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'hC0, 0, 1, 0);
    add(0, 2'd0, 1, 0, 8'h39, 1, 0, 0);
    add(0, 2'd2, 1, 1, 8'h39, 0, 1, 0);
    add(0, 2'd2, 1, 0, 8'h39, 0, 1, 0);
    add(0, 2'd2, 1, 0, 8'h39, 0, 1, 0);
    add(0, 2'd2, 1, 0, 8'hAA, 1, 0, 0);
    add(0, 2'd3, 1, 1, 8'hAA, 0, 1, 0);
    add(0, 2'd3, 1, 0, 8'hAA, 0, 1, 0);
    add(1, 2'd1, 1, 1, 8'h00, 0, 0, 0);
    add(0, 2'd1, 1, 0, 8'h00, 0, 0, 0);
    add(0, 2'd1, 1, 1, 8'h00, 0, 1, 0);
    add(0, 2'd1, 1, 0, 8'h00, 0, 1, 0);
    add(0, 2'd1, 1, 0, 8'h00, 0, 1, 0);
    add(0, 2'd2, 1, 0, 8'h95, 1, 0, 0);
    add(0, 2'd2, 0, 0, 8'h95, 0, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].din, tbl[i].v, tbl[i].fs);
      check("dout",       i, dout,              tbl[i].dout);
      check("dout_valid", i, FW'(dout_valid),   FW'(tbl[i].dv));
      check("busy",       i, FW'(busy),         FW'(tbl[i].busy));
      check("sync_err",   i, FW'(sync_err),     FW'(tbl[i].se));
    end

    // Randomized stream against the reference model, starting from reset.
    mq.delete();
    m_dout = '0; m_dv = 1'b0; m_se = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic              r;
      logic [DATA_W-1:0] d;
      logic              v;
      logic              fs;
      r  = (n == 0) || ($urandom_range(0, 49) == 0);
      d  = DATA_W'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 4) == 0);
      drive(r, d, v, fs);
      model_step(r, d, v, fs);
      check("rand_dout",       1000 + n, dout,            m_dout);
      check("rand_dout_valid", 1000 + n, FW'(dout_valid), FW'(m_dv));
      check("rand_busy",       1000 + n, FW'(busy),       FW'(mq.size() != 0));
      check("rand_sync_err",   1000 + n, FW'(sync_err),   FW'(m_se));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
Time-division demultiplexer: the receive-side counterpart of the team's select-driven mux. It accepts a serial stream of DATA_W-bit samples tagged by a frame marker and distributes consecutive samples into N_CH channel slots. A complete frame is presented in parallel with a one-cycle valid strobe. It sits downstream of any mux or serialiser that time-shares one data path among N_CH sources.

Parameters:
DATA_W, 2, width of each sample and of each channel slot.
N_CH, 4, channels per frame (>=1). Slot counter width is max(1, clog2(N_CH)).

Ports:
clk  input  1  clock; all logic is clocked on its rising edge.
rst  input  1  synchronous, active-high reset.
din  input  DATA_W  serial sample.
din_valid  input  1  din carries a sample this cycle.
frame_start  input  1  qualifies the current sample as slot 0; it is ignored when din_valid=0.
dout  output  N_CH*DATA_W  last completed frame; slot k is at dout[k*DATA_W +: DATA_W].
dout_valid  output  1  one-cycle pulse when dout updates.
busy  output  1  high while a frame is partially collected (state RUN).
sync_err  output  1  one-cycle pulse when frame_start arrives mid-frame.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, slot_cnt=0, staging=0, dout=0, dout_valid=0, busy=0, sync_err=0.
  - Reset overrides all inputs.
  - Reset mid-frame discards the partial frame. dout is cleared to 0.
- Only cycles with din_valid=1 are "accepted". When din_valid=0, every register holds, and dout_valid and sync_err are 0.
- IDLE:
  - Accepted sample with frame_start=1: staging[0]<=din, slot_cnt<=1, state<=RUN.
  - Accepted sample with frame_start=0: discarded, no state change, no error.
  - If N_CH=1, the frame completes immediately (see completion) and the state stays IDLE.
- RUN:
  - Accepted sample with frame_start=0: staging[slot_cnt]<=din, slot_cnt<=slot_cnt+1.
  - If slot_cnt==N_CH-1, the frame completes instead.
  - Accepted sample with frame_start=1 (resync): the partial frame is dropped, staging[0]<=din, slot_cnt<=1, state stays RUN, sync_err=1 for one cycle.
  - On resync, dout is not updated and dout_valid stays 0.
- Completion: on the edge that accepts the last slot:
  - dout<=staging with the final slot replaced by din.
  - dout_valid=1 in the following cycle only.
  - slot_cnt<=0, state<=IDLE.
- Latency: dout_valid is asserted the cycle after the last sample is accepted.
- Back-to-back frames: the next frame's frame_start may arrive the cycle right after the last slot. The stream must then run with no bubble: dout_valid pulses every N_CH accepted cycles.
- dout holds its value between completions. Staging is never visible on dout.
- busy is registered and equals (state==RUN).
- slot_cnt never exceeds N_CH-1. There is no wrap inside RUN because completion returns the block to IDLE.

Decomposition:
- Shared package demux_pkg holds:
  - state encoding: IDLE=1'b0, RUN=1'b1.
  - a clog2-based helper for the slot counter width.
- No sub-module. The state machine, slot counter and staging/output registers live in one module.

Test Plan (DATA_W=2, N_CH=4):
1. Assert rst for 2 cycles with random inputs -> dout=8'h00, dout_valid=0, busy=0, sync_err=0.
2. Send din=10(fs=1), 01, 11, 00 on consecutive valid cycles -> one cycle after the 4th sample, dout=8'h36 and dout_valid=1 for exactly one cycle; busy is 1 during slots 2-4, then 0.
3. Same frame with din_valid=0 bubbles between samples -> identical dout=8'h36, a single dout_valid pulse, and no register change during bubbles.
4. Send 11(fs=1), 11, then 01(fs=1), 10, 00, 11 -> sync_err pulses on the 3rd sample; the completed frame is dout=8'hC9 ({11,00,10,01}); no dout_valid for the aborted frame.
5. Send samples with fs=0 while IDLE, then a valid frame 00,00,00,11 -> leading samples are ignored, dout=8'hC0.
6. Two back-to-back frames, then rst asserted after slot 2 of a third frame -> two dout_valid pulses 4 cycles apart; after reset dout=0, busy=0, and a new frame collects correctly.
